// File: rtl/ringbuffer_hexdump.sv
// ringbuffer_hexdump: drains the LPC capture ring buffer one entry at a time,
// sending each entry as uppercase ASCII hex followed by CR LF over a
// valid/ready byte stream, then acknowledging it with read_done.
module ringbuffer_hexdump #(
  parameter int unsigned BITS   = 7,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              empty,
  input  logic [BITS-1:0]   read_addr,
  output logic [BITS-1:0]   rd_addr,
  output logic              rd_en,
  input  logic [DATA_W-1:0] rd_data,
  output logic              read_done,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic              busy
);

  localparam int unsigned NIB   = DATA_W / 4;
  localparam int unsigned CNT_W = (NIB > 1) ? $clog2(NIB) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NIB - 1);

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    LATCH,
    NIBBLE,
    CR,
    LF,
    DONE
  } state_t;

  state_t            state;
  logic [DATA_W-1:0] word;
  logic [DATA_W-1:0] word_shl;
  logic [CNT_W-1:0]  cnt;
  logic              accept;

  // Nibble value to uppercase ASCII hex digit.
  function automatic logic [7:0] hex_ascii(input logic [3:0] n);
    return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
  endfunction

  // The RAM address simply follows the ring buffer read pointer.
  assign rd_addr  = read_addr;
  assign accept   = tx_valid & tx_ready;
  assign word_shl = word << 4;

  // Drain FSM; every output is registered and updated alongside the state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      rd_en     <= 1'b0;
      read_done <= 1'b0;
      tx_valid  <= 1'b0;
      tx_data   <= 8'h00;
      busy      <= 1'b0;
      word      <= '0;
      cnt       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (!empty) begin
            state <= FETCH;
            rd_en <= 1'b1;
            busy  <= 1'b1;
          end
        end
        FETCH: begin
          rd_en <= 1'b0;
          state <= LATCH;
        end
        LATCH: begin
          word     <= rd_data;
          cnt      <= CNT_LAST;
          tx_valid <= 1'b1;
          tx_data  <= hex_ascii(rd_data[DATA_W-1 -: 4]);
          state    <= NIBBLE;
        end
        NIBBLE: begin
          if (accept) begin
            word <= word_shl;
            if (cnt == '0) begin
              tx_data <= 8'h0D;
              state   <= CR;
            end else begin
              cnt     <= cnt - CNT_W'(1);
              tx_data <= hex_ascii(word_shl[DATA_W-1 -: 4]);
            end
          end
        end
        CR: begin
          if (accept) begin
            tx_data <= 8'h0A;
            state   <= LF;
          end
        end
        LF: begin
          if (accept) begin
            tx_valid  <= 1'b0;
            read_done <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          read_done <= 1'b0;
          busy      <= 1'b0;
          state     <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/ringbuffer_hexdump.md
# ringbuffer_hexdump

Downstream drain stage for the LPC capture ring buffer. Watches the buffer's `empty` flag. For each stored entry it:
- reads the entry from the buffer RAM at the buffer's `read_addr`;
- emits the entry as uppercase ASCII hex, MSB nibble first, followed by CR LF, over a valid/ready byte stream into the UART transmitter;
- pulses `read_done` so the ring buffer advances its read pointer.

It handles one entry at a time and never drops or duplicates one.

## Interface
Parameters:
- `BITS`, 7: buffer address width; must match the ring buffer instance.
- `DATA_W`, 32: entry width in bits; must be a multiple of 4, range 4..64.

Ports:
- `clk`  in  1  single system clock; all logic is on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `empty`  in  1  ring buffer empty flag.
- `read_addr`  in  BITS  ring buffer read pointer; passed through to the RAM.
- `rd_addr`  out  BITS  RAM read address; combinational copy of `read_addr`.
- `rd_en`  out  1  RAM read strobe; one-cycle pulse.
- `rd_data`  in  DATA_W  RAM read data; valid the cycle after `rd_en`.
- `read_done`  out  1  one-cycle pulse; the entry is consumed.
- `tx_data`  out  8  ASCII byte to the UART.
- `tx_valid`  out  1  `tx_data` is valid.
- `tx_ready`  in  1  UART accepts the byte this cycle.
- `busy`  out  1  high in every state except IDLE.

## Operation
- State machine states: IDLE, FETCH, LATCH, NIBBLE, CR, LF, DONE.
- IDLE: when `empty`=0 at a clock edge, go to FETCH. Otherwise stay.
- FETCH: `rd_en`=1 for exactly this cycle. Always go to LATCH.
- LATCH: capture `rd_data` into the shift register `word`. Load the nibble counter with DATA_W/4−1. Go to NIBBLE.
- NIBBLE: `tx_valid`=1 and `tx_data`=hex(`word`[DATA_W−1:DATA_W−4]).
  - On `tx_valid`&`tx_ready`: shift `word` left by 4.
  - If the counter is 0, go to CR; otherwise decrement the counter.
- CR: `tx_data`=0x0D, `tx_valid`=1. On accept, go to LF.
- LF: `tx_data`=0x0A, `tx_valid`=1. On accept, go to DONE.
- DONE: `read_done`=1 for this cycle only. Go to IDLE.
- Hex encoding: nibble n in 0..9 → 0x30+n; n in 10..15 → 0x41+(n−10), i.e. uppercase A–F.
- Handshake rules:
  - `tx_data` is stable while `tx_valid`=1 and `tx_ready`=0.
  - `tx_valid` never drops before acceptance, except on reset.
  - `tx_valid`=0 in IDLE, FETCH, LATCH and DONE.
- `empty` is sampled only in IDLE. Changes to `empty` or `read_addr` during a transfer are ignored.
- The captured `word` is frozen after LATCH; later RAM writes do not affect the entry being sent.
- Reset has priority over everything.
  - Reset mid-transfer returns the FSM to IDLE and drops `tx_valid` in the following cycle.
  - No `read_done` is issued, so the entry stays in the buffer and is re-sent in full afterwards.

## Timing
- Reset values: state=IDLE, `rd_en`=0, `read_done`=0, `tx_valid`=0, `tx_data`=0x00, `busy`=0, `word`=0, counter=0.
- Latency:
  - `empty`=0 sampled at edge t → `rd_en`=1 in cycle t+1.
  - The first `tx_valid` appears in cycle t+3.
- Throughput with `tx_ready` held 1: one byte per cycle. Each entry produces DATA_W/4+2 bytes; DATA_W=32 gives 10 bytes.
- Cost per entry with no backpressure: DATA_W/4+6 cycles from IDLE back to IDLE.
  - LF accepted at edge k → `read_done` high in cycle k+1 → IDLE in cycle k+2.
  - `empty` is next sampled at edge k+2, which gives the ring buffer one cycle to update its flags.
- Backpressure: each cycle with `tx_ready`=0 stretches the current byte by exactly one cycle.
- Boundaries:
  - Buffer full or wrapping at address 2^BITS−1 → 0 needs no special handling; `rd_addr` follows `read_addr`.
  - `read_done` is never asserted while `empty`=1 was the last value sampled in IDLE.

## Test plan
- Reset: hold `reset`=1 for 2 cycles with `empty`=0 → all outputs at their reset values; no `rd_en` until the cycle after `reset` falls.
- Single entry: `rd_data`=0x1234ABCD, `empty` 1→0, `tx_ready`=1 → bytes 31 32 33 34 41 42 43 44 0D 0A on consecutive cycles, first byte 3 cycles after `empty` is sampled low; exactly one `read_done` pulse, one cycle after 0x0A.
- Backpressure: same entry, `tx_ready` toggled 1,0,0,1,… → identical byte sequence; `tx_data` stable across stalls; one `read_done`.
- Back-to-back: three entries 0x00000000, 0xFFFFFFFF, 0x0F0F0F0F with `empty` low throughout → "00000000\r\n", "FFFFFFFF\r\n", "0F0F0F0F\r\n"; 3 `read_done` pulses spaced 14 cycles apart; `rd_addr` follows 0,1,2.
- Reset mid-transfer: assert `reset` after the 4th byte of 0xDEADBEEF → `tx_valid`=0 the next cycle, no `read_done`; after release the full "DEADBEEF\r\n" is re-sent.
- Idle: `empty`=1 for 100 cycles → `rd_en`, `tx_valid`, `read_done` and `busy` all stay 0.
